// File: rtl/gateway_q.sv
// gateway_q: bridges local program-fetch and data load/store requests onto
// the shared external bus through a DEPTH-entry request FIFO.
//
// Ports:
//   sys_clk, resetl, ce         clock, synchronous active-low reset, bus-clock enable
//   req_*                       local request handshake and payload (queued)
//   dmaen, bus_hog              bus-request routing and hold-timer enable
//   gpu_breq, dma_breq,
//   bus_grant                   arbiter handshake
//   ext_*                       external bus cycle (strobe, address, width, data)
//   prog_req/prog_ack/prog_data program-fetch response, held until accepted
//   xld_ready/load_data         data-load response, one ce-tick pulse
//   gate_active                 high whenever the controller is not idle
//
// State table:
//   IDLE | nothing queued, no bus request
//   REQ  | requesting the bus for the head entry, or holding it (hog timer)
//   ACT  | bus cycle for the head entry in progress, waiting for ext_ack

module gateway_q #(
    parameter int AW    = 24,
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int HOG   = 4
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic          ce,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_prog,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic [DW-1:0] req_wdata,
    input  logic          dmaen,
    input  logic          bus_hog,
    output logic          gpu_breq,
    output logic          dma_breq,
    input  logic          bus_grant,
    output logic          ext_mreq,
    output logic          ext_read,
    output logic [AW-1:0] ext_addr,
    output logic [3:0]    ext_width,
    output logic          ext_oe,
    output logic [DW-1:0] ext_wdata,
    output logic          ext_wdata_oe,
    input  logic          ext_ack,
    input  logic [DW-1:0] ext_rdata,
    output logic          prog_req,
    input  logic          prog_ack,
    output logic [31:0]   prog_data,
    output logic          xld_ready,
    output logic [DW-1:0] load_data,
    output logic          gate_active
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (HOG > 0) ? $clog2(HOG + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          prog;
        logic          write;
        logic [1:0]    size;
        logic [DW-1:0] wdata;
    } entry_t;

    state_t        state, state_nxt;
    entry_t        mem [DEPTH];
    entry_t        head, wr_entry;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          fifo_empty, fifo_full;
    logic          push, pop;
    logic          act;
    logic          use_dma;
    logic          prog_block;

    logic          rsp_pend;
    logic          rsp_prog;
    logic [1:0]    rsp_size;
    logic [DW-1:0] rsp_buf;
    logic [DW-1:0] load_mask;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // ---------------------------------------------------------------
    // Request FIFO
    // ---------------------------------------------------------------
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    // Readiness looks only at the registered fill level, so a pop in the
    // same tick never lets an extra push in.
    assign req_ready  = ~fifo_full;
    assign head       = mem[rd_ptr];

    assign push = ce & req_valid & ~fifo_full;
    assign pop  = ce & (state == ACT) & bus_grant & ext_ack;

    always_comb begin
        wr_entry.addr  = req_addr;
        wr_entry.prog  = req_prog;
        wr_entry.write = req_write & ~req_prog;
        wr_entry.size  = req_prog ? 2'd2 : req_size;
        wr_entry.wdata = req_wdata;
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (ce) begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Bus-hog hold timer
    // ---------------------------------------------------------------
    always_comb begin
        hold_nxt = hold_cnt;
        if (!bus_hog) begin
            hold_nxt = '0;
        end else if (pop && head.prog) begin
            hold_nxt = HW'(HOG);
        end else if (hold_cnt != '0) begin
            hold_nxt = hold_cnt - HW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            hold_cnt <= '0;
        end else if (ce) begin
            hold_cnt <= hold_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    // A program fetch must not start while a previous fetch result is still
    // unaccepted or still sitting in the response stage.
    assign prog_block = prog_req | (rsp_pend & rsp_prog);

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty || hold_cnt != '0) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (!fifo_empty) begin
                    if (bus_grant && !(head.prog && prog_block)) begin
                        state_nxt = ACT;
                    end
                end else if (hold_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            ACT: begin
                // Losing the grant abandons the cycle; the entry stays at the
                // head and is re-arbitrated from REQ.
                if (!bus_grant) begin
                    state_nxt = REQ;
                end else if (ext_ack) begin
                    if (count_nxt != '0 || hold_nxt != '0) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign act         = (state == ACT);
    assign gate_active = (state != IDLE);

    // With an empty FIFO the request is only being held after a program
    // fetch, which belongs to the GPU side.
    assign use_dma  = ~fifo_empty & ~head.prog & dmaen;
    assign gpu_breq = gate_active & ~use_dma;
    assign dma_breq = gate_active & use_dma;

    assign ext_oe       = bus_grant;
    assign ext_mreq     = act;
    assign ext_read     = act & ~head.write;
    assign ext_addr     = act ? head.addr : '0;
    assign ext_width    = act ? (4'b0001 << head.size) : 4'b0000;
    assign ext_wdata_oe = act & head.write;
    assign ext_wdata    = (act && head.write) ? head.wdata : '0;

    // ---------------------------------------------------------------
    // Response stage: read data is captured on ack and presented on the
    // following ce tick.
    // ---------------------------------------------------------------
    always_comb begin
        load_mask = '1;
        case (rsp_size)
            2'd0:    load_mask = DW'(8'hFF);
            2'd1:    load_mask = DW'(16'hFFFF);
            2'd2:    load_mask = DW'(32'hFFFF_FFFF);
            default: load_mask = '1;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            rsp_pend  <= 1'b0;
            rsp_prog  <= 1'b0;
            rsp_size  <= 2'd0;
            rsp_buf   <= '0;
            prog_req  <= 1'b0;
            prog_data <= '0;
            xld_ready <= 1'b0;
            load_data <= '0;
        end else if (ce) begin
            xld_ready <= 1'b0;
            if (prog_ack) begin
                prog_req <= 1'b0;
            end
            if (rsp_pend) begin
                rsp_pend <= 1'b0;
                if (rsp_prog) begin
                    prog_data <= rsp_buf[31:0];
                    prog_req  <= 1'b1;
                end else begin
                    load_data <= rsp_buf & load_mask;
                    xld_ready <= 1'b1;
                end
            end
            if (pop && (head.prog || !head.write)) begin
                rsp_pend <= 1'b1;
                rsp_buf  <= ext_rdata;
                rsp_prog <= head.prog;
                rsp_size <= head.size;
            end
        end
    end

endmodule

// File: tb/tb_gateway_q.sv
// tb_gateway_q: directed self-checking bench for gateway_q (DW=32, DEPTH=2,
// HOG=4). Inputs change 1 ns after each rising edge; outputs are sampled there.

module tb_gateway_q;

    logic        sys_clk = 1'b0;
    logic        resetl;
    logic        ce;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        req_prog;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        dmaen;
    logic        bus_hog;
    logic        gpu_breq;
    logic        dma_breq;
    logic        bus_grant;
    logic        ext_mreq;
    logic        ext_read;
    logic [23:0] ext_addr;
    logic [3:0]  ext_width;
    logic        ext_oe;
    logic [31:0] ext_wdata;
    logic        ext_wdata_oe;
    logic        ext_ack;
    logic [31:0] ext_rdata;
    logic        prog_req;
    logic        prog_ack;
    logic [31:0] prog_data;
    logic        xld_ready;
    logic [31:0] load_data;
    logic        gate_active;

    int n_checks = 0;
    int n_fail   = 0;

    gateway_q #(.AW(24), .DW(32), .DEPTH(2), .HOG(4)) dut (
        .sys_clk      (sys_clk),
        .resetl       (resetl),
        .ce           (ce),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_prog     (req_prog),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_wdata    (req_wdata),
        .dmaen        (dmaen),
        .bus_hog      (bus_hog),
        .gpu_breq     (gpu_breq),
        .dma_breq     (dma_breq),
        .bus_grant    (bus_grant),
        .ext_mreq     (ext_mreq),
        .ext_read     (ext_read),
        .ext_addr     (ext_addr),
        .ext_width    (ext_width),
        .ext_oe       (ext_oe),
        .ext_wdata    (ext_wdata),
        .ext_wdata_oe (ext_wdata_oe),
        .ext_ack      (ext_ack),
        .ext_rdata    (ext_rdata),
        .prog_req     (prog_req),
        .prog_ack     (prog_ack),
        .prog_data    (prog_data),
        .xld_ready    (xld_ready),
        .load_data    (load_data),
        .gate_active  (gate_active)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [23:0] a, input logic prog, input logic wr,
                             input logic [1:0] sz, input logic [31:0] wd);
        req_valid = 1'b1;
        req_addr  = a;
        req_prog  = prog;
        req_write = wr;
        req_size  = sz;
        req_wdata = wd;
    endtask

    // Single load with grant present throughout and an immediate ack.
    task automatic run_load(input logic [23:0] a, input logic [1:0] sz, input logic [31:0] rd,
                            input logic [31:0] exp_ld, input logic [3:0] exp_w);
        bus_grant = 1'b1;
        drive_req(a, 1'b0, 1'b0, sz, 32'h0);
        step();
        req_valid = 1'b0;
        check_eq("ld_breq_push_tick", gpu_breq, 0);
        step();
        check_eq("ld_breq", gpu_breq, 1);
        check_eq("ld_mreq_early", ext_mreq, 0);
        step();
        check_eq("ld_mreq", ext_mreq, 1);
        check_eq("ld_addr", ext_addr, a);
        check_eq("ld_width", ext_width, exp_w);
        check_eq("ld_read", ext_read, 1);
        check_eq("ld_oe", ext_oe, 1);
        ext_ack   = 1'b1;
        ext_rdata = rd;
        step();
        ext_ack   = 1'b0;
        ext_rdata = 32'h0;
        check_eq("ld_xld_at_ack", xld_ready, 0);
        check_eq("ld_mreq_off", ext_mreq, 0);
        step();
        check_eq("ld_xld", xld_ready, 1);
        check_eq("ld_data", load_data, exp_ld);
        step();
        check_eq("ld_xld_pulse", xld_ready, 0);
        check_eq("ld_idle", gate_active, 0);
    endtask

    initial begin
        resetl    = 1'b0;
        ce        = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_prog  = 1'b0;
        req_write = 1'b0;
        req_size  = 2'd0;
        req_wdata = '0;
        dmaen     = 1'b0;
        bus_hog   = 1'b0;
        bus_grant = 1'b0;
        ext_ack   = 1'b0;
        ext_rdata = '0;
        prog_ack  = 1'b0;

        // Reset values
        step();
        step();
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_gpu_breq", gpu_breq, 0);
        check_eq("rst_dma_breq", dma_breq, 0);
        check_eq("rst_mreq", ext_mreq, 0);
        check_eq("rst_xld", xld_ready, 0);
        check_eq("rst_prog_req", prog_req, 0);
        check_eq("rst_active", gate_active, 0);
        check_eq("rst_load_data", load_data, 0);
        resetl = 1'b1;
        step();

        // Loads: 32-bit, byte, 16-bit
        run_load(24'h001234, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0100);
        run_load(24'h001235, 2'd0, 32'h12345678, 32'h00000078, 4'b0001);
        run_load(24'h001236, 2'd1, 32'h12345678, 32'h00005678, 4'b0010);

        // ce low: nothing is queued and nothing moves
        ce = 1'b0;
        drive_req(24'h000500, 1'b0, 1'b0, 2'd2, 32'h0);
        step();
        step();
        check_eq("ce_off_active", gate_active, 0);
        check_eq("ce_off_ready", req_ready, 1);
        req_valid = 1'b0;
        ce = 1'b1;
        step();
        step();
        check_eq("ce_off_no_push", gate_active, 0);

        // FIFO fill with grant withheld, then drain in order
        bus_grant = 1'b0;
        drive_req(24'h000A00, 1'b0, 1'b0, 2'd2, 32'h0);
        step();
        check_eq("fill_ready1", req_ready, 1);
        drive_req(24'h000A04, 1'b0, 1'b0, 2'd2, 32'h0);
        step();
        check_eq("fill_ready_full", req_ready, 0);
        drive_req(24'h000A08, 1'b0, 1'b0, 2'd2, 32'h0);
        step();
        check_eq("fill_ready_held", req_ready, 0);
        check_eq("fill_no_mreq", ext_mreq, 0);
        check_eq("fill_breq", gpu_breq, 1);
        bus_grant = 1'b1;
        step();
        check_eq("drain0_mreq", ext_mreq, 1);
        check_eq("drain0_addr", ext_addr, 24'h000A00);
        ext_ack = 1'b1;
        step();
        ext_ack = 1'b0;
        check_eq("drain_ready_after_pop", req_ready, 1);
        check_eq("drain_mreq_gap", ext_mreq, 0);
        step();
        req_valid = 1'b0;
        step();
        check_eq("drain1_mreq", ext_mreq, 1);
        check_eq("drain1_addr", ext_addr, 24'h000A04);
        check_eq("drain1_ready_full", req_ready, 0);
        ext_ack = 1'b1;
        step();
        ext_ack = 1'b0;
        step();
        step();
        check_eq("drain2_mreq", ext_mreq, 1);
        check_eq("drain2_addr", ext_addr, 24'h000A08);
        ext_ack = 1'b1;
        step();
        ext_ack = 1'b0;
        step();
        step();
        check_eq("drain_done_mreq", ext_mreq, 0);
        check_eq("drain_done_idle", gate_active, 0);
        check_eq("drain_done_ready", req_ready, 1);

        // Program fetch with hold timer, FIFO then empty
        bus_hog = 1'b1;
        drive_req(24'h000100, 1'b1, 1'b1, 2'd0, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        check_eq("pf_breq", gpu_breq, 1);
        step();
        check_eq("pf_mreq", ext_mreq, 1);
        check_eq("pf_width_forced", ext_width, 4'b0100);
        check_eq("pf_read", ext_read, 1);
        ext_ack   = 1'b1;
        ext_rdata = 32'h11223344;
        step();
        ext_ack   = 1'b0;
        ext_rdata = 32'h0;
        check_eq("hog_t0", gpu_breq, 1);
        step();
        check_eq("hog_t1", gpu_breq, 1);
        check_eq("pf_prog_req", prog_req, 1);
        check_eq("pf_prog_data", prog_data, 32'h11223344);
        check_eq("pf_no_xld", xld_ready, 0);
        prog_ack = 1'b1;
        step();
        prog_ack = 1'b0;
        check_eq("hog_t2", gpu_breq, 1);
        check_eq("pf_prog_req_clr", prog_req, 0);
        step();
        check_eq("hog_t3", gpu_breq, 1);
        step();
        check_eq("hog_drop", gpu_breq, 0);
        check_eq("hog_idle", gate_active, 0);

        // Second fetch; a load pushed during the hold window reuses the grant
        drive_req(24'h000104, 1'b1, 1'b0, 2'd2, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        step();
        check_eq("pf2_mreq", ext_mreq, 1);
        ext_ack   = 1'b1;
        ext_rdata = 32'h55667788;
        step();
        ext_ack   = 1'b0;
        ext_rdata = 32'h0;
        check_eq("hogld_t0", gpu_breq, 1);
        step();
        check_eq("hogld_t1", gpu_breq, 1);
        check_eq("pf2_prog_data", prog_data, 32'h55667788);
        prog_ack = 1'b1;
        drive_req(24'h000300, 1'b0, 1'b0, 2'd2, 32'h0);
        step();
        prog_ack  = 1'b0;
        req_valid = 1'b0;
        check_eq("hogld_t2", gpu_breq, 1);
        step();
        check_eq("hogld_mreq", ext_mreq, 1);
        check_eq("hogld_addr", ext_addr, 24'h000300);
        check_eq("hogld_t3", gpu_breq, 1);
        ext_ack   = 1'b1;
        ext_rdata = 32'hA5A5A5A5;
        step();
        ext_ack   = 1'b0;
        ext_rdata = 32'h0;
        check_eq("hogld_done_breq", gpu_breq, 0);
        step();
        check_eq("hogld_xld", xld_ready, 1);
        check_eq("hogld_data", load_data, 32'hA5A5A5A5);
        bus_hog = 1'b0;
        step();

        // DMA-routed store
        dmaen = 1'b1;
        drive_req(24'h002000, 1'b0, 1'b1, 2'd2, 32'hCAFEF00D);
        step();
        req_valid = 1'b0;
        step();
        check_eq("st_dma_breq", dma_breq, 1);
        check_eq("st_gpu_breq", gpu_breq, 0);
        step();
        check_eq("st_mreq", ext_mreq, 1);
        check_eq("st_read", ext_read, 0);
        check_eq("st_wdata_oe", ext_wdata_oe, 1);
        check_eq("st_wdata", ext_wdata, 32'hCAFEF00D);
        ext_ack = 1'b1;
        step();
        ext_ack = 1'b0;
        check_eq("st_wdata_oe_off", ext_wdata_oe, 0);
        check_eq("st_dma_drop", dma_breq, 0);
        step();
        check_eq("st_no_xld1", xld_ready, 0);
        step();
        check_eq("st_no_xld2", xld_ready, 0);
        dmaen = 1'b0;

        // Grant lost mid-cycle: the cycle re-issues and completes once
        drive_req(24'h000400, 1'b0, 1'b0, 2'd2, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        step();
        check_eq("lg_mreq", ext_mreq, 1);
        bus_grant = 1'b0;
        step();
        check_eq("lg_mreq_drop", ext_mreq, 0);
        check_eq("lg_breq_kept", gpu_breq, 1);
        check_eq("lg_oe", ext_oe, 0);
        bus_grant = 1'b1;
        step();
        check_eq("lg_reissue_mreq", ext_mreq, 1);
        check_eq("lg_reissue_addr", ext_addr, 24'h000400);
        ext_ack   = 1'b1;
        ext_rdata = 32'h0BADF00D;
        step();
        ext_ack   = 1'b0;
        ext_rdata = 32'h0;
        step();
        check_eq("lg_xld", xld_ready, 1);
        check_eq("lg_data", load_data, 32'h0BADF00D);
        step();

        // Reset during ACT with the FIFO full
        drive_req(24'h000600, 1'b0, 1'b0, 2'd2, 32'h0);
        step();
        drive_req(24'h000604, 1'b0, 1'b0, 2'd2, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        check_eq("rstact_mreq", ext_mreq, 1);
        check_eq("rstact_full", req_ready, 0);
        resetl = 1'b0;
        step();
        check_eq("rstact_mreq_off", ext_mreq, 0);
        check_eq("rstact_gpu_breq", gpu_breq, 0);
        check_eq("rstact_dma_breq", dma_breq, 0);
        check_eq("rstact_ready", req_ready, 1);
        resetl = 1'b1;
        step();
        step();
        step();
        check_eq("rstact_no_issue", ext_mreq, 0);
        check_eq("rstact_idle", gate_active, 0);
        check_eq("rstact_no_breq", gpu_breq, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
